// File: rtl/i2c_slave_model_param_if.sv
// I2C slave model bus bundle: raw SCL/SDA lines plus the register-bank strobe port.
// Signals: SCL_IN/SDA_IN (bus in), SDA_OE (open-drain pull), WR_STB/RD_STB/ADR/WDATA/RDATA (bank), BUSY.
interface i2c_slave_model_param_if #(
    parameter int ADR_BYTES  = 1,
    parameter int DATA_BYTES = 1
);
    logic                    SCL_IN;
    logic                    SDA_IN;
    logic                    SDA_OE;
    logic                    WR_STB;
    logic                    RD_STB;
    logic [8*ADR_BYTES-1:0]  ADR;
    logic [8*DATA_BYTES-1:0] WDATA;
    logic [8*DATA_BYTES-1:0] RDATA;
    logic                    BUSY;

    modport slave (
        input  SCL_IN, SDA_IN, RDATA,
        output SDA_OE, WR_STB, RD_STB, ADR, WDATA, BUSY
    );

    modport master (
        output SCL_IN, SDA_IN, RDATA,
        input  SDA_OE, WR_STB, RD_STB, ADR, WDATA, BUSY
    );
endinterface

// File: rtl/i2c_slave_model_param.sv
// Parametrised I2C slave: decodes raw SCL/SDA, presents words to a register bank via strobes.
// Ports: CLK, RST (async, active-high), bus (slave modport: SCL/SDA in, SDA_OE, WR/RD strobes, ADR, data, BUSY).
module i2c_slave_model_param #(
    parameter logic [6:0] DEV_ADR     = 7'h50,
    parameter int         ADR_BYTES   = 1,
    parameter int         DATA_BYTES  = 1,
    parameter bit         AUTO_INC    = 1'b1,
    parameter int         SYNC_STAGES = 2
) (
    input logic                    CLK,
    input logic                    RST,
    i2c_slave_model_param_if.slave bus
);
    localparam int AW = 8 * ADR_BYTES;
    localparam int DW = 8 * DATA_BYTES;
    localparam int RW = (AW > DW) ? AW : DW;

    typedef enum logic [3:0] {
        IDLE, DEV, DEV_ACK, ADR_SH, ADR_ACK,
        WR_SH, WR_ACK, RD_SH, RD_ACK, WAIT_STOP
    } state_t;

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] scl_sync_q, scl_sync_d;
    logic [SYNC_STAGES-1:0] sda_sync_q, sda_sync_d;
    logic                   scl_prev_q, scl_prev_d;
    logic                   sda_prev_q, sda_prev_d;
    logic [2:0]             bit_cnt_q, bit_cnt_d;
    logic [1:0]             byte_cnt_q, byte_cnt_d;
    logic [RW-1:0]          rx_q, rx_d;
    logic [DW-1:0]          tx_q, tx_d;
    logic [AW-1:0]          adr_q, adr_d;
    logic [DW-1:0]          wdata_q, wdata_d;
    logic                   sda_oe_q, sda_oe_d;
    logic                   wr_stb_q, wr_stb_d;
    logic                   rd_stb_q, rd_stb_d;
    logic                   rd_load_q, rd_load_d;

    logic scl_s, sda_s;
    logic start_ev, stop_ev, scl_rise, scl_fall;
    logic last_bit, last_adr, last_data;

    assign scl_s     = scl_sync_q[SYNC_STAGES-1];
    assign sda_s     = sda_sync_q[SYNC_STAGES-1];
    assign start_ev  = scl_s & scl_prev_q & sda_prev_q & ~sda_s;
    assign stop_ev   = scl_s & scl_prev_q & ~sda_prev_q & sda_s;
    assign scl_rise  = scl_s & ~scl_prev_q;
    assign scl_fall  = ~scl_s & scl_prev_q;
    assign last_bit  = (bit_cnt_q == 3'd7);
    assign last_adr  = (byte_cnt_q == 2'(ADR_BYTES - 1));
    assign last_data = (byte_cnt_q == 2'(DATA_BYTES - 1));

    always_comb begin
        scl_sync_d = {scl_sync_q[SYNC_STAGES-2:0], bus.SCL_IN};
        sda_sync_d = {sda_sync_q[SYNC_STAGES-2:0], bus.SDA_IN};
        scl_prev_d = scl_s;
        sda_prev_d = sda_s;
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        byte_cnt_d = byte_cnt_q;
        rx_d       = rx_q;
        tx_d       = tx_q;
        adr_d      = adr_q;
        wdata_d    = wdata_q;
        sda_oe_d   = sda_oe_q;
        wr_stb_d   = 1'b0;
        rd_stb_d   = 1'b0;
        rd_load_d  = rd_stb_q;

        // Bank answers RD_STB one cycle later; capture its word then.
        if (rd_load_q) tx_d = bus.RDATA;
        // Write strobe shows the old pointer; advance it the cycle after.
        if (wr_stb_q) adr_d = adr_q + AW'(AUTO_INC);

        if (stop_ev) begin
            state_d    = IDLE;
            bit_cnt_d  = 3'd0;
            byte_cnt_d = 2'd0;
            sda_oe_d   = 1'b0;
        end else if (start_ev) begin
            state_d    = DEV;
            bit_cnt_d  = 3'd0;
            byte_cnt_d = 2'd0;
            sda_oe_d   = 1'b0;
        end else if (scl_fall) begin
            // SDA only moves while SCL is low, decided by the state
            // reached at the preceding rising edge.
            unique case (state_q)
                DEV_ACK, ADR_ACK, WR_ACK: sda_oe_d = 1'b1;
                RD_SH:                    sda_oe_d = ~tx_q[DW-1];
                default:                  sda_oe_d = 1'b0;
            endcase
        end else if (scl_rise) begin
            unique case (state_q)
                DEV: begin
                    rx_d      = {rx_q[RW-2:0], sda_s};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (last_bit) begin
                        bit_cnt_d = 3'd0;
                        state_d   = (rx_q[6:0] == DEV_ADR) ? DEV_ACK
                                                           : WAIT_STOP;
                    end
                end
                DEV_ACK: begin
                    byte_cnt_d = 2'd0;
                    if (rx_q[0]) begin
                        state_d  = RD_SH;
                        rd_stb_d = 1'b1;
                    end else begin
                        state_d  = ADR_SH;
                    end
                end
                ADR_SH, WR_SH: begin
                    rx_d      = {rx_q[RW-2:0], sda_s};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (last_bit) begin
                        bit_cnt_d = 3'd0;
                        state_d   = (state_q == ADR_SH) ? ADR_ACK : WR_ACK;
                    end
                end
                ADR_ACK: begin
                    if (last_adr) begin
                        adr_d      = rx_q[AW-1:0];
                        byte_cnt_d = 2'd0;
                        state_d    = WR_SH;
                    end else begin
                        byte_cnt_d = byte_cnt_q + 2'd1;
                        state_d    = ADR_SH;
                    end
                end
                WR_ACK: begin
                    state_d = WR_SH;
                    if (last_data) begin
                        byte_cnt_d = 2'd0;
                        wr_stb_d   = 1'b1;
                        wdata_d    = rx_q[DW-1:0];
                    end else begin
                        byte_cnt_d = byte_cnt_q + 2'd1;
                    end
                end
                RD_SH: begin
                    tx_d      = {tx_q[DW-2:0], 1'b0};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (last_bit) begin
                        bit_cnt_d = 3'd0;
                        state_d   = RD_ACK;
                    end
                end
                RD_ACK: begin
                    if (!sda_s) begin
                        state_d = RD_SH;
                        if (last_data) begin
                            byte_cnt_d = 2'd0;
                            adr_d      = adr_q + AW'(AUTO_INC);
                            rd_stb_d   = 1'b1;
                        end else begin
                            byte_cnt_d = byte_cnt_q + 2'd1;
                        end
                    end else begin
                        state_d = WAIT_STOP;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q    <= IDLE;
            scl_sync_q <= '1;
            sda_sync_q <= '1;
            scl_prev_q <= 1'b1;
            sda_prev_q <= 1'b1;
            bit_cnt_q  <= 3'd0;
            byte_cnt_q <= 2'd0;
            rx_q       <= '0;
            tx_q       <= '0;
            adr_q      <= '0;
            wdata_q    <= '0;
            sda_oe_q   <= 1'b0;
            wr_stb_q   <= 1'b0;
            rd_stb_q   <= 1'b0;
            rd_load_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            scl_sync_q <= scl_sync_d;
            sda_sync_q <= sda_sync_d;
            scl_prev_q <= scl_prev_d;
            sda_prev_q <= sda_prev_d;
            bit_cnt_q  <= bit_cnt_d;
            byte_cnt_q <= byte_cnt_d;
            rx_q       <= rx_d;
            tx_q       <= tx_d;
            adr_q      <= adr_d;
            wdata_q    <= wdata_d;
            sda_oe_q   <= sda_oe_d;
            wr_stb_q   <= wr_stb_d;
            rd_stb_q   <= rd_stb_d;
            rd_load_q  <= rd_load_d;
        end
    end

    assign bus.SDA_OE = sda_oe_q;
    assign bus.WR_STB = wr_stb_q;
    assign bus.RD_STB = rd_stb_q;
    assign bus.ADR    = adr_q;
    assign bus.WDATA  = wdata_q;
    assign bus.BUSY   = (state_q != IDLE);
endmodule

// File: tb/tb_i2c_slave_model_param.sv
// Bench for i2c_slave_model_param: two slaves (8b/8b at 0x50, 16b/32b at 0x28) on one bus.
// A bit-banged master drives traffic; a queue/array model predicts strobes, pointers and read data.
module tb_i2c_slave_model_param;
    localparam int H = 80;
    localparam int Q = 40;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic m_scl = 1'b1;
    logic m_sda = 1'b1;
    logic sda_line;

    int n_checks = 0;
    int n_errs   = 0;

    i2c_slave_model_param_if #(.ADR_BYTES(1), .DATA_BYTES(1)) if0 ();
    i2c_slave_model_param_if #(.ADR_BYTES(2), .DATA_BYTES(4)) if1 ();

    i2c_slave_model_param #(
        .DEV_ADR(7'h50), .ADR_BYTES(1), .DATA_BYTES(1),
        .AUTO_INC(1'b1), .SYNC_STAGES(2)
    ) u0 (.CLK(clk), .RST(rst), .bus(if0.slave));

    i2c_slave_model_param #(
        .DEV_ADR(7'h28), .ADR_BYTES(2), .DATA_BYTES(4),
        .AUTO_INC(1'b1), .SYNC_STAGES(3)
    ) u1 (.CLK(clk), .RST(rst), .bus(if1.slave));

    always #5 clk = ~clk;

    assign sda_line   = m_sda & ~if0.SDA_OE & ~if1.SDA_OE;
    assign if0.SCL_IN = m_scl;
    assign if0.SDA_IN = sda_line;
    assign if1.SCL_IN = m_scl;
    assign if1.SDA_IN = sda_line;

    // Register bank (environment) and reference memory (model).
    logic [7:0] bank0 [256];
    logic [7:0] ref0  [256];
    logic [7:0]  ad0;
    logic [15:0] ad1;

    function automatic logic [31:0] rd1f(input logic [15:0] a);
        return {a, ~a} ^ 32'hC3A5_5A3C;
    endfunction

    assign if0.RDATA = bank0[if0.ADR];
    assign if1.RDATA = rd1f(if1.ADR);

    logic [15:0] wq0 [$];
    logic [7:0]  rq0 [$];
    logic [47:0] wq1 [$];
    logic [15:0] rq1 [$];
    logic [7:0]  dq  [$];

    always @(negedge clk) begin
        if (if0.WR_STB) begin
            wq0.push_back({if0.ADR, if0.WDATA});
            bank0[if0.ADR] <= if0.WDATA;
        end
        if (if0.RD_STB) rq0.push_back(if0.ADR);
        if (if1.WR_STB) wq1.push_back({if1.ADR, if1.WDATA});
        if (if1.RD_STB) rq1.push_back(if1.ADR);
    end

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic i2c_start();
        m_sda = 1'b1; #Q;
        m_scl = 1'b1; #H;
        m_sda = 1'b0; #H;
        m_scl = 1'b0; #Q;
    endtask

    task automatic i2c_stop();
        m_sda = 1'b0; #Q;
        m_scl = 1'b1; #H;
        m_sda = 1'b1; #H;
    endtask

    task automatic i2c_wr(input logic [7:0] b, output logic ack);
        for (int i = 7; i >= 0; i--) begin
            m_sda = b[i]; #Q;
            m_scl = 1'b1; #H;
            m_scl = 1'b0; #Q;
        end
        m_sda = 1'b1; #Q;
        m_scl = 1'b1; #(H/2);
        ack = ~sda_line; #(H/2);
        m_scl = 1'b0; #Q;
    endtask

    task automatic i2c_rd(input logic last, output logic [7:0] b);
        m_sda = 1'b1;
        for (int i = 7; i >= 0; i--) begin
            #Q;
            m_scl = 1'b1; #(H/2);
            b[i] = sda_line; #(H/2);
            m_scl = 1'b0;
            #Q;
        end
        m_sda = last; #Q;
        m_scl = 1'b1; #H;
        m_scl = 1'b0; #Q;
        m_sda = 1'b1;
    endtask

    // Write dq to slave 0 at register a.
    task automatic wr0(input string tag, input logic [7:0] a);
        logic ack;
        int acks;
        logic [15:0] exp_q [$];
        wq0.delete();
        acks = 0;
        i2c_start();
        check({tag, "_busy1"}, 64'(if0.BUSY), 64'd1);
        i2c_wr(8'hA0, ack); acks += int'(ack);
        i2c_wr(a, ack);     acks += int'(ack);
        ad0 = a;
        foreach (dq[k]) begin
            i2c_wr(dq[k], ack); acks += int'(ack);
            exp_q.push_back({ad0, dq[k]});
            ref0[ad0] = dq[k];
            ad0 = ad0 + 8'd1;
        end
        i2c_stop();
        check({tag, "_ack"}, 64'(acks), 64'(dq.size() + 2));
        check({tag, "_nwr"}, 64'(wq0.size()), 64'(exp_q.size()));
        foreach (exp_q[k])
            if (k < wq0.size())
                check({tag, "_wr"}, 64'(wq0[k]), 64'(exp_q[k]));
        check({tag, "_adr"}, 64'(if0.ADR), 64'(ad0));
        check({tag, "_busy0"}, 64'(if0.BUSY), 64'd0);
    endtask

    // Write dq to slave 1 at register a; only whole 4-byte words strobe.
    task automatic wr1(input string tag, input logic [15:0] a);
        logic ack;
        int acks;
        logic [31:0] w;
        logic [47:0] exp_q [$];
        wq1.delete();
        acks = 0;
        i2c_start();
        i2c_wr(8'h50, ack);    acks += int'(ack);
        i2c_wr(a[15:8], ack);  acks += int'(ack);
        i2c_wr(a[7:0], ack);   acks += int'(ack);
        ad1 = a;
        foreach (dq[k]) begin
            i2c_wr(dq[k], ack); acks += int'(ack);
            w = {w[23:0], dq[k]};
            if (k % 4 == 3) begin
                exp_q.push_back({ad1, w});
                ad1 = ad1 + 16'd1;
            end
        end
        i2c_stop();
        check({tag, "_ack"}, 64'(acks), 64'(dq.size() + 3));
        check({tag, "_nwr"}, 64'(wq1.size()), 64'(exp_q.size()));
        foreach (exp_q[k])
            if (k < wq1.size())
                check({tag, "_wr"}, 64'(wq1[k]), 64'(exp_q[k]));
        check({tag, "_adr"}, 64'(if1.ADR), 64'(ad1));
    endtask

    // Read n bytes from slave 0, optionally setting the pointer first.
    task automatic rd0(input string tag, input bit with_adr,
                       input logic [7:0] a, input int n);
        logic ack;
        logic [7:0] b;
        rq0.delete();
        i2c_start();
        if (with_adr) begin
            i2c_wr(8'hA0, ack);
            check({tag, "_aack0"}, 64'(ack), 64'd1);
            i2c_wr(a, ack);
            check({tag, "_aack1"}, 64'(ack), 64'd1);
            ad0 = a;
            i2c_start();
        end
        i2c_wr(8'hA1, ack);
        check({tag, "_dack"}, 64'(ack), 64'd1);
        for (int k = 0; k < n; k++) begin
            i2c_rd(k == n - 1, b);
            check({tag, "_rd"}, 64'(b), 64'(ref0[8'(ad0 + 8'(k))]));
        end
        check({tag, "_rel"}, 64'(if0.SDA_OE), 64'd0);
        i2c_stop();
        check({tag, "_nrs"}, 64'(rq0.size()), 64'(n));
        foreach (rq0[k])
            check({tag, "_rsa"}, 64'(rq0[k]), 64'(8'(ad0 + 8'(k))));
        ad0 = 8'(ad0 + 8'(n - 1));
        check({tag, "_adr"}, 64'(if0.ADR), 64'(ad0));
    endtask

    // Read nw words from slave 1 at the current pointer.
    task automatic rd1(input string tag, input int nw);
        logic ack;
        logic [7:0] b;
        logic [31:0] w;
        rq1.delete();
        i2c_start();
        i2c_wr(8'h51, ack);
        check({tag, "_dack"}, 64'(ack), 64'd1);
        for (int j = 0; j < 4 * nw; j++) begin
            i2c_rd(j == 4 * nw - 1, b);
            w = rd1f(16'(ad1 + 16'(j / 4)));
            check({tag, "_rd"}, 64'(b), 64'(w[8*(3 - j % 4) +: 8]));
        end
        check({tag, "_rel"}, 64'(if1.SDA_OE), 64'd0);
        i2c_stop();
        check({tag, "_nrs"}, 64'(rq1.size()), 64'(nw));
        foreach (rq1[k])
            check({tag, "_rsa"}, 64'(rq1[k]), 64'(16'(ad1 + 16'(k))));
        ad1 = 16'(ad1 + 16'(nw - 1));
        check({tag, "_adr"}, 64'(if1.ADR), 64'(ad1));
    endtask

    task automatic fill(input int n);
        dq.delete();
        for (int k = 0; k < n; k++) dq.push_back(8'($urandom));
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog time limit reached");
        $fatal(1);
    end

    initial begin
        logic ack;
        logic [7:0] b;
        for (int i = 0; i < 256; i++) begin
            bank0[i] = 8'($urandom);
            ref0[i]  = bank0[i];
        end
        ad0 = 8'd0;
        ad1 = 16'd0;

        repeat (4) @(posedge clk);
        #2;
        check("rst_oe", 64'(if0.SDA_OE | if1.SDA_OE), 64'd0);
        check("rst_stb", 64'({if0.WR_STB, if0.RD_STB, if1.WR_STB, if1.RD_STB}), 64'd0);
        check("rst_adr", 64'({if0.ADR, if1.ADR}), 64'd0);
        check("rst_wd", 64'({if0.WDATA, if1.WDATA}), 64'd0);
        check("rst_busy", 64'({if0.BUSY, if1.BUSY}), 64'd0);
        rst = 1'b0;
        #40;

        // Single-byte write to 0x12.
        fill(0); dq.push_back(8'h5A);
        wr0("t1", 8'h12);
        check("t1_wdata", 64'(if0.WDATA), 64'h5A);

        // Two 32-bit words at 0x0104.
        fill(8);
        wr1("t2", 16'h0104);

        // Pointer set, repeated START, two-byte read.
        rd0("t3", 1'b1, 8'h20, 2);

        // Foreign address: NACK and ignore until STOP.
        wq0.delete(); wq1.delete(); rq0.delete(); rq1.delete();
        i2c_start();
        i2c_wr(8'hA2, ack);
        check("t4_nack", 64'(ack), 64'd0);
        check("t4_busy", 64'(if0.BUSY), 64'd1);
        i2c_wr(8'hA0, ack);
        check("t4_ign0", 64'(ack), 64'd0);
        i2c_wr(8'h33, ack);
        check("t4_ign1", 64'(ack), 64'd0);
        i2c_stop();
        check("t4_nstb", 64'(wq0.size() + wq1.size() + rq0.size() + rq1.size()), 64'd0);
        fill(2);
        wr0("t4b", 8'h40);

        // Partial word discarded, then pointer wrap on both slaves.
        fill(2);
        wr1("t5p", 16'h0300);
        fill(1);
        wr0("t5w", 8'hFF);
        fill(4);
        wr1("t5w1", 16'hFFFF);

        // Reset while the slave is driving ACK.
        i2c_start();
        b = 8'hA0;
        for (int i = 7; i >= 0; i--) begin
            m_sda = b[i]; #Q;
            m_scl = 1'b1; #H;
            m_scl = 1'b0; #Q;
        end
        m_sda = 1'b1; #Q;
        m_scl = 1'b1; #(H/2);
        check("t6_ack_on", 64'(if0.SDA_OE), 64'd1);
        @(posedge clk);
        #1 rst = 1'b1;
        #1 check("t6_oe_rst", 64'(if0.SDA_OE), 64'd0);
        check("t6_adr_rst", 64'({if0.ADR, if1.ADR}), 64'd0);
        check("t6_busy_rst", 64'({if0.BUSY, if1.BUSY}), 64'd0);
        check("t6_wd_rst", 64'({if0.WDATA, if1.WDATA}), 64'd0);
        @(posedge clk);
        #2;
        m_scl = 1'b0;
        rst = 1'b0;
        ad0 = 8'd0;
        ad1 = 16'd0;
        #Q;
        i2c_stop();
        fill(3);
        wr0("t6n", 8'h07);

        // Random traffic against the model.
        for (int t = 0; t < 8; t++) begin
            case ($urandom_range(3))
                0: begin
                    fill(int'($urandom_range(1, 4)));
                    wr0("rw0", 8'($urandom));
                end
                1: rd0("rr0", 1'($urandom), 8'($urandom),
                       int'($urandom_range(1, 3)));
                2: begin
                    fill(int'($urandom_range(1, 9)));
                    wr1("rw1", 16'($urandom));
                end
                default: rd1("rr1", int'($urandom_range(1, 2)));
            endcase
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
        $finish;
    end
endmodule
